wbu_commit_stage: RTL and testbench

//  Write-back/commit stage downstream of the execute/LSU stage. Accepts one retired instruction per
//  EXU_valid/WBU_ready handshake, commits GPR and CSR writes, computes the next PC (sequential, branch,
//  jal/jalr, ecall trap, mret), then hands npc to the IFU via a valid/ready handshake. Owns the GPR file
//  (combinational read ports feed the IDU) and the machine CSRs (mstatus, mtvec, mepc, mcause).

---
 rtl/wbu_pkg.sv | 22 ++
 rtl/wbu_commit_stage_if.sv | 42 ++++
 rtl/wbu_commit_stage_gpr_file.sv | 31 +++
 rtl/wbu_commit_stage.sv | 92 +++++++++
 tb/tb_wbu_commit_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbu_pkg.sv
// Shared constants, state type and next-PC helper for the write-back/commit stage.
package wbu_pkg;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  typedef enum logic {S_IDLE, S_NOTIFY} wbu_state_e;

  // Sequential / branch / jal / jalr target; jalr clears bit 0 of the sum.
  function automatic logic [31:0] seq_npc(input logic [31:0] pc, input logic [31:0] src1,
                                          input logic [31:0] imm, input logic pc_asrc,
                                          input logic pc_bsrc);
    logic [31:0] sum;
    sum = (pc_bsrc ? src1 : pc) + (pc_asrc ? imm : 32'd4);
    if (pc_bsrc) sum[0] = 1'b0;
    return sum;
  endfunction

endpackage

// File: rtl/wbu_commit_stage_if.sv
// Bus between EXU/IDU/IFU (master side) and the commit stage (slave side).
interface wbu_commit_stage_if;
  // Both handshakes are strict valid/ready: a transfer happens on a rising clk edge where
  // valid & ready are both 1; valid never waits on ready, and the payload is only sampled
  // at that edge (exu_valid/wbu_ready for retirement, wbu_valid/ifu_ready for npc).
  logic        exu_valid;
  logic        wbu_ready;
  logic [31:0] pc;
  logic [31:0] src1;
  logic [31:0] imm;
  logic        pc_asrc;
  logic        pc_bsrc;
  logic        regwr;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic        csrw;
  logic [11:0] csr_waddr;
  logic [31:0] csrwdata;
  logic        ecall;
  logic        mret;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        wbu_valid;
  logic        ifu_ready;
  logic [31:0] npc;

  modport master (
    output exu_valid, pc, src1, imm, pc_asrc, pc_bsrc, regwr, rd, wd,
           csrw, csr_waddr, csrwdata, ecall, mret, rs1_addr, rs2_addr, csr_raddr, ifu_ready,
    input  wbu_ready, rs1_data, rs2_data, csr_rdata, wbu_valid, npc
  );

  modport slave (
    input  exu_valid, pc, src1, imm, pc_asrc, pc_bsrc, regwr, rd, wd,
           csrw, csr_waddr, csrwdata, ecall, mret, rs1_addr, rs2_addr, csr_raddr, ifu_ready,
    output wbu_ready, rs1_data, rs2_data, csr_rdata, wbu_valid, npc
  );
endinterface

// File: rtl/wbu_commit_stage_gpr_file.sv
// General-purpose register file: one write port, two asynchronous read ports, x0 hard-wired to 0.
module gpr_file #(
  parameter int unsigned NR_GPR = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);
  localparam int unsigned AW = $clog2(NR_GPR);
  localparam logic [5:0]  NR = 6'(NR_GPR);

  logic [31:0] regs [NR_GPR];

  // Indices outside the implemented file are dropped on write and read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0 && {1'b0, waddr} < NR) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = (raddr1 != 5'd0 && {1'b0, raddr1} < NR) ? regs[raddr1[AW-1:0]] : 32'd0;
  assign rdata2 = (raddr2 != 5'd0 && {1'b0, raddr2} < NR) ? regs[raddr2[AW-1:0]] : 32'd0;
endmodule

// File: rtl/wbu_commit_stage.sv
// Write-back/commit stage: commits GPR/CSR writes, resolves the next PC and hands it to the IFU.
module wbu_commit_stage
  import wbu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h3000_0000,
  parameter int unsigned NR_GPR        = 16,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic                 clk,
  input  logic                 rst,
  wbu_commit_stage_if.slave    bus,
  output wbu_state_e           dbg_state
);
  wbu_state_e  state;
  logic [31:0] npc_q;
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic [31:0] next_npc;
  logic        fire;
  logic        gpr_we;

  assign fire   = (state == S_IDLE) && bus.exu_valid;
  // Traps and returns suppress the architectural writes of the retiring instruction.
  assign gpr_we = fire && bus.regwr && !bus.ecall && !bus.mret;

  always_comb begin
    next_npc = seq_npc(bus.pc, bus.src1, bus.imm, bus.pc_asrc, bus.pc_bsrc);
    if (bus.ecall)     next_npc = mtvec;
    else if (bus.mret) next_npc = mepc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_NOTIFY;
      npc_q   <= RESET_PC;
      mstatus <= MSTATUS_RESET;
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.exu_valid) begin
            state <= S_NOTIFY;
            npc_q <= next_npc;
            if (bus.ecall) begin
              mepc   <= bus.pc;
              mcause <= MCAUSE_ECALL_M;
            end else if (!bus.mret && bus.csrw) begin
              case (bus.csr_waddr)
                CSR_MSTATUS: mstatus <= bus.csrwdata;
                CSR_MTVEC:   mtvec   <= bus.csrwdata;
                CSR_MEPC:    mepc    <= bus.csrwdata;
                CSR_MCAUSE:  mcause  <= bus.csrwdata;
                default: ;
              endcase
            end
          end
        end
        S_NOTIFY: if (bus.ifu_ready) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.csr_rdata = 32'd0;
    case (bus.csr_raddr)
      CSR_MSTATUS: bus.csr_rdata = mstatus;
      CSR_MTVEC:   bus.csr_rdata = mtvec;
      CSR_MEPC:    bus.csr_rdata = mepc;
      CSR_MCAUSE:  bus.csr_rdata = mcause;
      default: ;
    endcase
  end

  assign bus.wbu_ready = (state == S_IDLE);
  assign bus.wbu_valid = (state == S_NOTIFY);
  assign bus.npc       = npc_q;
  assign dbg_state     = state;

  gpr_file #(.NR_GPR(NR_GPR)) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .we     (gpr_we),
    .waddr  (bus.rd),
    .wdata  (bus.wd),
    .raddr1 (bus.rs1_addr),
    .rdata1 (bus.rs1_data),
    .raddr2 (bus.rs2_addr),
    .rdata2 (bus.rs2_data)
  );
endmodule

// File: tb/tb_wbu_commit_stage.sv
// Bench for wbu_commit_stage: directed table, hand-written reset sequences, random traffic vs model.
module tb_wbu_commit_stage;
  import wbu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int          NGPR     = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] imm;
    logic        pc_asrc;
    logic        pc_bsrc;
    logic        regwr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        csrw;
    logic [11:0] csr_waddr;
    logic [31:0] csrwdata;
    logic        ecall;
    logic        mret;
    logic [31:0] exp_npc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wbu_commit_stage_if bus();
  wbu_state_e dbg_state;

  wbu_commit_stage #(.RESET_PC(RESET_PC), .NR_GPR(NGPR), .MSTATUS_RESET(32'h0000_1800)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_gpr [32];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_mstatus = 32'h0000_1800;
    m_mtvec   = 32'd0;
    m_mepc    = 32'd0;
    m_mcause  = 32'd0;
  endtask

  function automatic logic [31:0] m_gpr_read(input logic [4:0] a);
    return (int'(a) < NGPR) ? m_gpr[a] : 32'd0;
  endfunction

  function automatic logic [31:0] m_csr_read(input logic [11:0] a);
    if (a == 12'h300) return m_mstatus;
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'd0;
  endfunction

  task automatic model_commit(input vec_t v, output logic [31:0] npc_e);
    longint unsigned base, off;
    if (v.ecall) begin
      npc_e    = m_mtvec;
      m_mepc   = v.pc;
      m_mcause = 32'd11;
    end else if (v.mret) begin
      npc_e = m_mepc;
    end else begin
      base  = v.pc_bsrc ? longint'(v.src1) : longint'(v.pc);
      off   = v.pc_asrc ? longint'(v.imm) : 64'd4;
      npc_e = 32'((base + off) % 64'h1_0000_0000);
      if (v.pc_bsrc) npc_e = npc_e & 32'hFFFF_FFFE;
      if (v.regwr && v.rd != 5'd0 && int'(v.rd) < NGPR) m_gpr[v.rd] = v.wd;
      if (v.csrw) begin
        if (v.csr_waddr == 12'h300) m_mstatus = v.csrwdata;
        if (v.csr_waddr == 12'h305) m_mtvec   = v.csrwdata;
        if (v.csr_waddr == 12'h341) m_mepc    = v.csrwdata;
        if (v.csr_waddr == 12'h342) m_mcause  = v.csrwdata;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.exu_valid = 1'b0; bus.ifu_ready = 1'b0;
    bus.pc = '0; bus.src1 = '0; bus.imm = '0; bus.pc_asrc = 1'b0; bus.pc_bsrc = 1'b0;
    bus.regwr = 1'b0; bus.rd = '0; bus.wd = '0; bus.csrw = 1'b0; bus.csr_waddr = '0;
    bus.csrwdata = '0; bus.ecall = 1'b0; bus.mret = 1'b0;
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.csr_raddr = '0;
  endtask

  task automatic check_arch(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      check({tag, "_rs1"}, bus.rs1_data, m_gpr_read(5'(i)));
      check({tag, "_rs2"}, bus.rs2_data, m_gpr_read(5'(31 - i)));
    end
    for (int i = 0; i < 5; i++) begin
      logic [11:0] csr_list [5];
      csr_list = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
      bus.csr_raddr = csr_list[i];
      #1;
      check({tag, "_csr"}, bus.csr_rdata, m_csr_read(csr_list[i]));
    end
    @(posedge clk); #1;
  endtask

  task automatic apply(input vec_t v, input bit use_tbl, input int hold, input string tag);
    logic [31:0] e, got_e;
    int n = 0;
    while (!bus.wbu_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, "_wait_idle"}, 32'(bus.wbu_ready), 32'd1);
    bus.pc = v.pc; bus.src1 = v.src1; bus.imm = v.imm; bus.pc_asrc = v.pc_asrc;
    bus.pc_bsrc = v.pc_bsrc; bus.regwr = v.regwr; bus.rd = v.rd; bus.wd = v.wd;
    bus.csrw = v.csrw; bus.csr_waddr = v.csr_waddr; bus.csrwdata = v.csrwdata;
    bus.ecall = v.ecall; bus.mret = v.mret; bus.rs1_addr = v.rd; bus.exu_valid = 1'b1;
    #1;
    // No bypass: before the edge the read port must still show the old value.
    check({tag, "_pre_edge_read"}, bus.rs1_data, m_gpr_read(v.rd));
    model_commit(v, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.exu_valid = 1'b0;
    bus.pc = $urandom; bus.src1 = $urandom; bus.imm = $urandom; bus.ecall = 1'($urandom);
    bus.mret = 1'($urandom); bus.pc_bsrc = 1'($urandom);
    got_e = exp_q.pop_front();
    check({tag, "_wbu_valid"}, 32'(bus.wbu_valid), 32'd1);
    check({tag, "_wbu_ready"}, 32'(bus.wbu_ready), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_NOTIFY));
    check({tag, "_npc"}, bus.npc, got_e);
    if (use_tbl) check({tag, "_npc_table"}, bus.npc, v.exp_npc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_npc_hold"}, bus.npc, got_e);
    end
    bus.ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(bus.wbu_ready), 32'd1);
    idle_inputs();
    check_arch(tag);
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] src1, input logic [31:0] imm,
                              input logic asrc, input logic bsrc, input logic regwr, input logic [4:0] rd,
                              input logic [31:0] wd, input logic csrw, input logic [11:0] ca,
                              input logic [31:0] cd, input logic ecall, input logic mret,
                              input logic [31:0] exp_npc);
    vec_t v;
    v.pc = pc; v.src1 = src1; v.imm = imm; v.pc_asrc = asrc; v.pc_bsrc = bsrc;
    v.regwr = regwr; v.rd = rd; v.wd = wd; v.csrw = csrw; v.csr_waddr = ca; v.csrwdata = cd;
    v.ecall = ecall; v.mret = mret; v.exp_npc = exp_npc;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl [8];

  initial begin
    tbl[0] = mk(32'h3000_0010, 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 12'h0, 32'h0, 0, 0, 32'h3000_0014);
    tbl[1] = mk(32'h3000_0014, 32'h8000_0003, 32'h4, 1, 1, 1, 5'd0, 32'h1234_5678, 0, 12'h0, 32'h0, 0, 0, 32'h8000_0006);
    tbl[2] = mk(32'h8000_0006, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1, 12'h305, 32'h8000_0100, 0, 0, 32'h8000_000A);
    tbl[3] = mk(32'h8000_0040, 32'h0, 32'h0, 0, 0, 1, 5'd6, 32'h5555_5555, 1, 12'h300, 32'h0, 1, 0, 32'h8000_0100);
    tbl[4] = mk(32'h8000_0100, 32'h0, 32'h0, 0, 0, 1, 5'd7, 32'h7777_7777, 1, 12'h305, 32'h0, 0, 1, 32'h8000_0040);
    tbl[5] = mk(32'hFFFF_FFFC, 32'h0, 32'h8, 1, 0, 1, 5'd20, 32'h0000_0ABC, 0, 12'h0, 32'h0, 0, 0, 32'h0000_0004);
    tbl[6] = mk(32'h0000_0100, 32'h0, 32'h0, 0, 0, 1, 5'd3, 32'h8000_0040, 1, 12'h341, 32'h1111_0000, 0, 0, 32'h0000_0104);
    tbl[7] = mk(32'h0000_0200, 32'h0, 32'hFFFF_FFF0, 1, 0, 0, 5'd0, 32'h0, 1, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 32'h0000_01F0);

    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Out of reset the IFU is offered RESET_PC without any EXU traffic.
    check("rst_wbu_valid", 32'(bus.wbu_valid), 32'd1);
    check("rst_wbu_ready", 32'(bus.wbu_ready), 32'd0);
    check("rst_npc", bus.npc, RESET_PC);
    check("rst_state", 32'(dbg_state), 32'(S_NOTIFY));
    bus.csr_raddr = 12'h300; #1;
    check("rst_mstatus", bus.csr_rdata, 32'h0000_1800);
    // exu_valid in NOTIFY must be ignored while npc holds.
    bus.exu_valid = 1'b1; bus.regwr = 1'b1; bus.rd = 5'd1; bus.wd = 32'hBAD0_0001;
    bus.pc_asrc = 1'b1; bus.imm = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_npc_hold", bus.npc, RESET_PC);
      check("rst_valid_hold", 32'(bus.wbu_valid), 32'd1);
    end
    idle_inputs();
    bus.ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ready = 1'b0;
    check("kick_accepted_idle", 32'(bus.wbu_ready), 32'd1);
    check("kick_wbu_valid_low", 32'(bus.wbu_valid), 32'd0);
    check_arch("after_kick");

    for (int i = 0; i < 8; i++) apply(tbl[i], 1'b1, i % 3, $sformatf("tbl%0d", i));

    // Reset while an npc is pending and the IFU is stalled.
    apply(mk(32'h0000_1000, 32'h0, 32'h0, 0, 0, 1, 5'd9, 32'hCAFE_0009, 1, 12'h300, 32'h0000_0088, 0, 0, 32'h0000_1004),
          1'b1, 0, "pre_rst");
    apply(mk(32'h0000_2000, 32'h0, 32'h0, 0, 0, 1, 5'd10, 32'h0000_00AA, 0, 12'h0, 32'h0, 0, 0, 32'h0000_2004),
          1'b1, 0, "pre_rst2");
    bus.exu_valid = 1'b1; bus.pc = 32'h0000_3000; bus.regwr = 1'b1; bus.rd = 5'd11; bus.wd = 32'h1;
    @(posedge clk); #1;
    idle_inputs();
    check("mid_notify", 32'(bus.wbu_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("mid_rst_npc", bus.npc, RESET_PC);
    check("mid_rst_valid", 32'(bus.wbu_valid), 32'd1);
    bus.ifu_ready = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ready = 1'b0;
    check_arch("mid_rst");

    // Random traffic against the model.
    for (int k = 0; k < 150; k++) begin
      vec_t v;
      logic [11:0] ca_pick [5];
      ca_pick = '{12'h300, 12'h305, 12'h341, 12'h342, 12'(12'h000 + $urandom_range(0, 4095))};
      v.pc = $urandom; v.src1 = $urandom;
      v.imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      v.pc_asrc = 1'($urandom); v.pc_bsrc = 1'($urandom);
      v.regwr = 1'($urandom); v.rd = 5'($urandom_range(0, 31)); v.wd = $urandom;
      v.csrw = 1'($urandom); v.csr_waddr = ca_pick[$urandom_range(0, 4)]; v.csrwdata = $urandom;
      v.ecall = ($urandom_range(0, 9) == 0);
      v.mret  = ($urandom_range(0, 9) == 0);
      v.exp_npc = 32'd0;
      apply(v, 1'b0, $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
